// File: rtl/vrf_read_responder.sv
// vrf_read_responder
// Responder end of the VRF read-request channel. Each accepted request is
// issued to a fixed-latency SRAM bank in the same cycle. The request tags ride
// a tag pipeline that runs alongside the SRAM read, and the returning data is
// paired with its tags in a response FIFO. Admission is credit based: a request
// is accepted only while a FIFO slot is guaranteed for it. Because of this the
// tag pipeline never stalls and the FIFO never overflows.
//
// Optional build macro: VRF_READ_RESP_BYPASS_EN
//   When it is defined and the FIFO is empty, an arriving read is presented on
//   the response port in its arrival cycle. It skips the FIFO if the response
//   fires in that same cycle.
//
// Ports
//   clock, reset                     clock; synchronous active-high reset
//   io_req_ready / io_req_valid      request handshake
//   io_req_bits_vs, _offset          register index and element-group offset
//   io_req_bits_readSource           requester tag, echoed back unchanged
//   io_req_bits_instructionIndex     instruction tag, echoed back unchanged
//   io_sram_readEn, io_sram_addr     SRAM read strobe and address {vs, offset}
//   io_sram_readData                 valid READ_LATENCY cycles after readEn
//   io_resp_ready / io_resp_valid    response handshake
//   io_resp_bits_*                   read data plus echoed tags

module vrf_read_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  io_req_ready,
    input  logic                  io_req_valid,
    input  logic [4:0]            io_req_bits_vs,
    input  logic [7:0]            io_req_bits_offset,
    input  logic [3:0]            io_req_bits_readSource,
    input  logic [2:0]            io_req_bits_instructionIndex,
    output logic                  io_sram_readEn,
    output logic [12:0]           io_sram_addr,
    input  logic [DATA_WIDTH-1:0] io_sram_readData,
    input  logic                  io_resp_ready,
    output logic                  io_resp_valid,
    output logic [DATA_WIDTH-1:0] io_resp_bits_data,
    output logic [3:0]            io_resp_bits_readSource,
    output logic [2:0]            io_resp_bits_instructionIndex
);

    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [CW-1:0] C_FULL = CW'(RESP_DEPTH);
    localparam logic [PW-1:0] P_LAST = PW'(RESP_DEPTH - 1);

    logic [CW-1:0]         r_credits;
    logic [CW-1:0]         r_count;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;

    logic                  r_tag_vld [READ_LATENCY];
    logic [3:0]            r_tag_rs  [READ_LATENCY];
    logic [2:0]            r_tag_ii  [READ_LATENCY];

    logic [DATA_WIDTH-1:0] r_fifo_data [RESP_DEPTH];
    logic [3:0]            r_fifo_rs   [RESP_DEPTH];
    logic [2:0]            r_fifo_ii   [RESP_DEPTH];

    logic                  w_req_fire;
    logic                  w_arrive;
    logic                  w_fifo_empty;
    logic                  w_bypass;
    logic                  w_resp_fire;
    logic                  w_push;
    logic                  w_pop;

    // Request side: readiness depends only on credits, never on io_req_valid.
    assign io_req_ready   = (r_credits != '0) & ~reset;
    assign w_req_fire     = io_req_valid & io_req_ready;
    assign io_sram_readEn = w_req_fire;
    assign io_sram_addr   = {io_req_bits_vs, io_req_bits_offset};

    assign w_arrive     = r_tag_vld[READ_LATENCY-1];
    assign w_fifo_empty = (r_count == '0);

`ifdef VRF_READ_RESP_BYPASS_EN
    assign w_bypass = w_arrive & w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign io_resp_valid                 = ~w_fifo_empty | w_bypass;
    assign io_resp_bits_data             = w_bypass ? io_sram_readData : r_fifo_data[r_rd_ptr];
    assign io_resp_bits_readSource       = w_bypass ? r_tag_rs[READ_LATENCY-1] : r_fifo_rs[r_rd_ptr];
    assign io_resp_bits_instructionIndex = w_bypass ? r_tag_ii[READ_LATENCY-1] : r_fifo_ii[r_rd_ptr];

    assign w_resp_fire = io_resp_valid & io_resp_ready;
    // A bypassed response that fires never occupies a slot. Its credit still
    // comes back through w_resp_fire.
    assign w_pop       = w_resp_fire & ~w_fifo_empty;
    assign w_push      = w_arrive & ~(w_bypass & io_resp_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_credits <= C_FULL;
        end else begin
            case ({w_req_fire, w_resp_fire})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01:   r_credits <= r_credits + CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Tag pipeline valid bits. Clearing them on reset drops in-flight reads, so
    // any data the SRAM returns late is never captured.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_tag_vld[i] <= 1'b0;
            end
        end else begin
            r_tag_vld[0] <= w_req_fire;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        r_tag_rs[0] <= io_req_bits_readSource;
        r_tag_ii[0] <= io_req_bits_instructionIndex;
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_tag_rs[i] <= r_tag_rs[i-1];
            r_tag_ii[i] <= r_tag_ii[i-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == P_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == P_LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= io_sram_readData;
            r_fifo_rs[r_wr_ptr]   <= r_tag_rs[READ_LATENCY-1];
            r_fifo_ii[r_wr_ptr]   <= r_tag_ii[READ_LATENCY-1];
        end
    end

endmodule

// File: tb/tb_vrf_read_responder.sv
// Self-checking bench for vrf_read_responder. The reference model is a queue
// of expected responses in acceptance order, plus a credit count derived from
// handshake totals.
module tb_vrf_read_responder;

    localparam int L = 2;
    localparam int D = 4;
`ifdef VRF_READ_RESP_BYPASS_EN
    localparam int MINLAT = L;
`else
    localparam int MINLAT = L + 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_req_ready;
    logic        io_req_valid = 1'b0;
    logic [4:0]  io_req_bits_vs = '0;
    logic [7:0]  io_req_bits_offset = '0;
    logic [3:0]  io_req_bits_readSource = '0;
    logic [2:0]  io_req_bits_instructionIndex = '0;
    logic        io_sram_readEn;
    logic [12:0] io_sram_addr;
    logic [31:0] io_sram_readData;
    logic        io_resp_ready = 1'b0;
    logic        io_resp_valid;
    logic [31:0] io_resp_bits_data;
    logic [3:0]  io_resp_bits_readSource;
    logic [2:0]  io_resp_bits_instructionIndex;

    vrf_read_responder #(.DATA_WIDTH(32), .READ_LATENCY(L), .RESP_DEPTH(D)) dut (
        .clock(clock),
        .reset(reset),
        .io_req_ready(io_req_ready),
        .io_req_valid(io_req_valid),
        .io_req_bits_vs(io_req_bits_vs),
        .io_req_bits_offset(io_req_bits_offset),
        .io_req_bits_readSource(io_req_bits_readSource),
        .io_req_bits_instructionIndex(io_req_bits_instructionIndex),
        .io_sram_readEn(io_sram_readEn),
        .io_sram_addr(io_sram_addr),
        .io_sram_readData(io_sram_readData),
        .io_resp_ready(io_resp_ready),
        .io_resp_valid(io_resp_valid),
        .io_resp_bits_data(io_resp_bits_data),
        .io_resp_bits_readSource(io_resp_bits_readSource),
        .io_resp_bits_instructionIndex(io_resp_bits_instructionIndex)
    );

    always #5 clock = ~clock;

    // SRAM model: fixed-latency lookup into a random memory image.
    logic [31:0] mem [8192];
    logic [12:0] sh  [L];
    always @(posedge clock) begin
        sh[0] <= io_sram_addr;
        for (int i = 1; i < L; i++) sh[i] <= sh[i-1];
    end
    assign io_sram_readData = mem[sh[L-1]];

    typedef struct {
        logic [31:0] data;
        logic [3:0]  rs;
        logic [2:0]  ii;
        int          fc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   obs_cyc;
    int   m_cred = D;

    logic        o_req_ready, o_readEn, o_resp_valid;
    logic [12:0] o_addr;
    logic [31:0] o_data;
    logic [3:0]  o_rs;
    logic [2:0]  o_ii;
    logic        exp_req_ready, fire, rfire, sb_under, early;
    logic [31:0] exp_data;
    logic [3:0]  exp_rs;
    logic [2:0]  exp_ii;

    // Credits must stay within 0..D (an underflow wraps to a large value).
    always @(posedge clock) begin
        if (!reset) begin
            total++;
            if (dut.r_credits > D) begin
                bad++;
                $display("FAIL credit_bound: credits=%0d max=%0d", dut.r_credits, D);
            end
        end
    end

    // One cycle: drive the inputs at negedge, sample the outputs, and advance
    // the reference model. This task makes no comparisons.
    task automatic tick(input logic v, input logic [4:0] vs, input logic [7:0] off,
                        input logic [3:0] rs, input logic [2:0] ii, input logic rr);
        exp_t e;
        @(negedge clock);
        reset = 1'b0;
        io_req_valid = v;
        io_req_bits_vs = vs;
        io_req_bits_offset = off;
        io_req_bits_readSource = rs;
        io_req_bits_instructionIndex = ii;
        io_resp_ready = rr;
        #1;
        o_req_ready  = io_req_ready;
        o_readEn     = io_sram_readEn;
        o_addr       = io_sram_addr;
        o_resp_valid = io_resp_valid;
        o_data       = io_resp_bits_data;
        o_rs         = io_resp_bits_readSource;
        o_ii         = io_resp_bits_instructionIndex;
        exp_req_ready = (m_cred != 0);
        fire  = v & o_req_ready;
        rfire = o_resp_valid & rr;
        sb_under = 1'b0;
        early = 1'b0;
        exp_data = '0;
        exp_rs = '0;
        exp_ii = '0;
        obs_cyc = cyc;
        if (rfire) begin
            if (sb.size() == 0) begin
                sb_under = 1'b1;
            end else begin
                e = sb.pop_front();
                exp_data = e.data;
                exp_rs = e.rs;
                exp_ii = e.ii;
                early = (cyc < e.fc + MINLAT);
            end
        end
        if (fire) begin
            e.data = mem[{vs, off}];
            e.rs = rs;
            e.ii = ii;
            e.fc = cyc;
            sb.push_back(e);
        end
        m_cred = m_cred - (fire ? 1 : 0) + (rfire ? 1 : 0);
        cyc++;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        io_req_valid = 1'b1;
        io_resp_ready = 1'b1;
        #1;
        o_req_ready = io_req_ready;
        o_readEn = io_sram_readEn;
        sb.delete();
        m_cred = D;
        cyc++;
    endtask

    task automatic test_reset();
        pulse_reset();
        total++;
        if (o_req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got=%b exp=0", o_req_ready); end
        total++;
        if (o_readEn !== 1'b0) begin bad++; $display("FAIL reset_readEn: got=%b exp=0", o_readEn); end
        tick(0, 0, 0, 0, 0, 1);
        total++;
        if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got=%b exp=0", o_resp_valid); end
        total++;
        if (o_req_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready: got=%b exp=1", o_req_ready); end
    endtask

    task automatic test_single_read();
        int c0;
        int seen;
        seen = -1;
        tick(1, 5'h03, 8'h1A, 4'h2, 3'h5, 1);
        c0 = obs_cyc;
        total++;
        if (o_addr !== 13'h031A || o_readEn !== 1'b1) begin
            bad++; $display("FAIL single_issue: addr=%h en=%b exp addr=031a en=1", o_addr, o_readEn);
        end
        for (int k = 0; k < 10 && seen < 0; k++) begin
            tick(0, 0, 0, 0, 0, 1);
            if (o_resp_valid) begin
                seen = obs_cyc - c0;
                total++;
                if (o_data !== 32'hDEADBEEF || o_rs !== 4'h2 || o_ii !== 3'h5) begin
                    bad++; $display("FAIL single_resp: data=%h rs=%h ii=%h exp deadbeef 2 5", o_data, o_rs, o_ii);
                end
            end
        end
        total++;
        if (seen != MINLAT) begin bad++; $display("FAIL single_latency: got=%0d exp=%0d", seen, MINLAT); end
    endtask

    task automatic test_streaming();
        int n, first, last;
        logic bubble;
        n = 0; first = -1; last = -1; bubble = 1'b0;
        for (int k = 0; k < 36 && n < 16; k++) begin
            if (k < 16) tick(1, 5'($urandom), 8'($urandom), 4'($urandom), 3'($urandom), 1);
            else        tick(0, 0, 0, 0, 0, 1);
            if (k < 16) begin
                total++;
                if (o_req_ready !== 1'b1) begin bad++; $display("FAIL stream_ready: k=%0d got=%b exp=1", k, o_req_ready); end
            end
            if (rfire) begin
                if (first >= 0 && obs_cyc != last + 1) bubble = 1'b1;
                if (first < 0) first = obs_cyc;
                last = obs_cyc;
                n++;
                total++;
                if (sb_under || early || o_data !== exp_data || o_rs !== exp_rs || o_ii !== exp_ii) begin
                    bad++;
                    $display("FAIL stream_resp: data=%h rs=%h ii=%h early=%b under=%b exp data=%h rs=%h ii=%h",
                             o_data, o_rs, o_ii, early, sb_under, exp_data, exp_rs, exp_ii);
                end
            end
        end
        total++;
        if (n != 16) begin bad++; $display("FAIL stream_count: got=%0d exp=16", n); end
        total++;
        if (bubble) begin bad++; $display("FAIL stream_bubble: got bubble exp none"); end
    endtask

    task automatic test_backpressure();
        int acc, n;
        acc = 0; n = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1, 5'($urandom), 8'($urandom), 4'($urandom), 3'($urandom), 0);
            if (fire) acc++;
        end
        total++;
        if (acc != D) begin bad++; $display("FAIL bp_accepted: got=%0d exp=%0d", acc, D); end
        total++;
        if (o_req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got=%b exp=0", o_req_ready); end
        for (int k = 0; k < 10 && n < D; k++) begin
            tick(0, 0, 0, 0, 0, 1);
            if (k == 1) begin
                total++;
                if (o_req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_return: got=%b exp=1", o_req_ready); end
            end
            if (rfire) begin
                n++;
                total++;
                if (sb_under || o_data !== exp_data || o_rs !== exp_rs || o_ii !== exp_ii) begin
                    bad++;
                    $display("FAIL bp_resp: data=%h rs=%h ii=%h exp data=%h rs=%h ii=%h",
                             o_data, o_rs, o_ii, exp_data, exp_rs, exp_ii);
                end
            end
        end
        total++;
        if (n != D) begin bad++; $display("FAIL bp_drain: got=%0d exp=%0d", n, D); end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 8; k++) tick(1, 5'($urandom), 8'($urandom), 4'($urandom), 3'($urandom), 0);
        tick(1, 5'($urandom), 8'($urandom), 4'($urandom), 3'($urandom), 1);
        total++;
        if (o_req_ready !== 1'b0 || rfire !== 1'b1) begin
            bad++; $display("FAIL simul_first: ready=%b rfire=%b exp ready=0 rfire=1", o_req_ready, rfire);
        end
        total++;
        if (sb_under || o_data !== exp_data || o_rs !== exp_rs || o_ii !== exp_ii) begin
            bad++; $display("FAIL simul_resp: data=%h exp=%h", o_data, exp_data);
        end
        tick(1, 5'($urandom), 8'($urandom), 4'($urandom), 3'($urandom), 1);
        total++;
        if (o_req_ready !== 1'b1) begin bad++; $display("FAIL simul_ready_next: got=%b exp=1", o_req_ready); end
        for (int k = 0; k < 15 && sb.size() != 0; k++) begin
            tick(0, 0, 0, 0, 0, 1);
            if (rfire) begin
                total++;
                if (sb_under || o_data !== exp_data || o_rs !== exp_rs || o_ii !== exp_ii) begin
                    bad++; $display("FAIL simul_drain: data=%h rs=%h ii=%h exp data=%h rs=%h ii=%h",
                                    o_data, o_rs, o_ii, exp_data, exp_rs, exp_ii);
                end
            end
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL simul_left: got=%0d exp=0", sb.size()); end
    endtask

    task automatic test_reset_midflight();
        int n;
        logic any_valid;
        n = 0; any_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick(1, 5'($urandom), 8'($urandom), 4'($urandom), 3'($urandom), 0);
        pulse_reset();
        tick(0, 0, 0, 0, 0, 1);
        total++;
        if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL mid_resp_valid: got=%b exp=0", o_resp_valid); end
        total++;
        if (dut.r_credits != D) begin bad++; $display("FAIL mid_credits: got=%0d exp=%0d", dut.r_credits, D); end
        for (int k = 0; k < 6; k++) begin
            tick(0, 0, 0, 0, 0, 1);
            if (o_resp_valid) any_valid = 1'b1;
        end
        total++;
        if (any_valid) begin bad++; $display("FAIL mid_ghost: got response exp none"); end
        tick(1, 5'h1F, 8'h80, 4'hA, 3'h3, 1);
        for (int k = 0; k < 10 && n == 0; k++) begin
            tick(0, 0, 0, 0, 0, 1);
            if (rfire) begin
                n++;
                total++;
                if (sb_under || o_data !== mem[13'h1F80] || o_rs !== 4'hA || o_ii !== 3'h3) begin
                    bad++; $display("FAIL mid_new: data=%h rs=%h ii=%h exp data=%h rs=a ii=3",
                                    o_data, o_rs, o_ii, mem[13'h1F80]);
                end
            end
        end
        total++;
        if (n != 1) begin bad++; $display("FAIL mid_new_count: got=%0d exp=1", n); end
    endtask

    task automatic test_tag_integrity();
        int acc, n;
        acc = 0; n = 0;
        for (int k = 0; k < 200; k++) begin
            tick(logic'($urandom_range(0, 3) != 0), 5'($urandom), 8'($urandom), 4'($urandom),
                 3'($urandom), logic'($urandom_range(0, 1)));
            if (fire) acc++;
            total++;
            if (o_req_ready !== exp_req_ready) begin
                bad++; $display("FAIL tag_ready: k=%0d got=%b exp=%b", k, o_req_ready, exp_req_ready);
            end
            if (rfire) begin
                n++;
                total++;
                if (sb_under || early || o_data !== exp_data || o_rs !== exp_rs || o_ii !== exp_ii) begin
                    bad++; $display("FAIL tag_resp: data=%h rs=%h ii=%h exp data=%h rs=%h ii=%h",
                                    o_data, o_rs, o_ii, exp_data, exp_rs, exp_ii);
                end
            end
        end
        for (int k = 0; k < 20 && sb.size() != 0; k++) begin
            tick(0, 0, 0, 0, 0, 1);
            if (rfire) begin
                n++;
                total++;
                if (sb_under || o_data !== exp_data || o_rs !== exp_rs || o_ii !== exp_ii) begin
                    bad++; $display("FAIL tag_drain: data=%h exp=%h", o_data, exp_data);
                end
            end
        end
        total++;
        if (n != acc || sb.size() != 0) begin
            bad++; $display("FAIL tag_count: got=%0d exp=%0d left=%0d", n, acc, sb.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        mem[13'h031A] = 32'hDEADBEEF;
        repeat (2) @(negedge clock);
        test_reset();
        test_single_read();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_reset_midflight();
        test_tag_integrity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
